// File: rtl/falu_scheduler_if.sv
// Requester, ALU and response bundle for falu_scheduler.
// slave = scheduler side; master = requesters plus the ALU feeding results back.
interface falu_scheduler_if #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
);
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ-1:0][3:0]   req_op;
  logic [NUM_REQ-1:0][31:0]  req_op1;
  logic [NUM_REQ-1:0][31:0]  req_op2;
  logic [3:0]                alu_op;
  logic [31:0]               alu_op1;
  logic [31:0]               alu_op2;
  logic [31:0]               alu_result;
  logic                      alu_cmp;
  logic [NUM_REQ-1:0]        rsp_valid;
  logic [31:0]               rsp_result;
  logic                      rsp_cmp;
  logic [ID_W-1:0]           rsp_id;
  logic                      busy;

  modport slave (
    input  req_valid, req_op, req_op1, req_op2, alu_result, alu_cmp,
    output req_ready, alu_op, alu_op1, alu_op2, rsp_valid, rsp_result, rsp_cmp, rsp_id, busy
  );

  modport master (
    output req_valid, req_op, req_op1, req_op2, alu_result, alu_cmp,
    input  req_ready, alu_op, alu_op1, alu_op2, rsp_valid, rsp_result, rsp_cmp, rsp_id, busy
  );
endinterface

// File: rtl/falu_scheduler.sv
// Round-robin scheduler sharing one combinational float ALU among NUM_REQ requesters.
// ALU inputs are held for 1 cycle (DIV_CYCLES for divide), then the result returns as a one-cycle pulse.
module falu_sched_lane #(
  parameter int ID_W = 2,
  parameter int IDX  = 0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            capture,
  input  logic [ID_W-1:0] owner,
  output logic            rsp_vld
);
  always_ff @(posedge clk or posedge reset) begin
    if (reset) rsp_vld <= 1'b0;
    else       rsp_vld <= capture && (owner == ID_W'(IDX));
  end
endmodule

module falu_scheduler #(
  parameter int         NUM_REQ    = 4,
  parameter int         DIV_CYCLES = 4,
  parameter logic [3:0] FALU_DIV   = 4'h3
) (
  input  logic             clk,
  input  logic             reset,
  falu_scheduler_if.slave  bus
);
  localparam int ID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int SW    = ID_W + 1;
  localparam int CNT_W = ($clog2(DIV_CYCLES + 1) > 4) ? $clog2(DIV_CYCLES + 1) : 4;
  localparam logic [CNT_W-1:0] DIV_HOLD = CNT_W'(DIV_CYCLES);
  localparam logic [ID_W-1:0]  LAST     = ID_W'(NUM_REQ - 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t               state, state_nxt;
  logic [ID_W-1:0]      rr_ptr, owner, gnt_id;
  logic [CNT_W-1:0]     hold_cnt;
  logic [NUM_REQ-1:0]   gnt, rsp_vld;
  logic [SW-1:0]        scan;
  logic                 can_grant, capture, found, accept;
  logic [3:0]           alu_op_q;
  logic [31:0]          alu_op1_q, alu_op2_q, rsp_result_q;
  logic                 rsp_cmp_q;
  logic [ID_W-1:0]      rsp_id_q;

  assign capture   = (state == BUSY) && (hold_cnt == CNT_W'(1));
  // The capture cycle may grant too, which is what makes back-to-back single-cycle ops possible.
  assign can_grant = !reset && ((state == IDLE) || capture);

  always_comb begin
    gnt    = '0;
    gnt_id = rr_ptr;
    found  = 1'b0;
    scan   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan = {1'b0, rr_ptr} + SW'(k);
      if (scan >= SW'(NUM_REQ)) scan = scan - SW'(NUM_REQ);
      if (can_grant && !found && bus.req_valid[scan[ID_W-1:0]]) begin
        gnt[scan[ID_W-1:0]] = 1'b1;
        gnt_id              = scan[ID_W-1:0];
        found               = 1'b1;
      end
    end
  end

  assign accept        = found;
  assign bus.req_ready = gnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = BUSY;
      BUSY:    if (capture && !accept) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      alu_op_q     <= '0;
      alu_op1_q    <= '0;
      alu_op2_q    <= '0;
      rr_ptr       <= '0;
      owner        <= '0;
      hold_cnt     <= '0;
      rsp_result_q <= '0;
      rsp_cmp_q    <= 1'b0;
      rsp_id_q     <= '0;
    end else begin
      if (capture) begin
        rsp_result_q <= bus.alu_result;
        rsp_cmp_q    <= bus.alu_cmp;
        rsp_id_q     <= owner;
      end
      if (accept) begin
        alu_op_q  <= bus.req_op[gnt_id];
        alu_op1_q <= bus.req_op1[gnt_id];
        alu_op2_q <= bus.req_op2[gnt_id];
        owner     <= gnt_id;
        rr_ptr    <= (gnt_id == LAST) ? '0 : gnt_id + 1'b1;
        hold_cnt  <= (bus.req_op[gnt_id] == FALU_DIV) ? DIV_HOLD : CNT_W'(1);
      end else if ((state == BUSY) && (hold_cnt > CNT_W'(1))) begin
        hold_cnt <= hold_cnt - 1'b1;
      end
    end
  end

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
    falu_sched_lane #(.ID_W(ID_W), .IDX(i)) u_lane (
      .clk     (clk),
      .reset   (reset),
      .capture (capture),
      .owner   (owner),
      .rsp_vld (rsp_vld[i])
    );
  end

  assign bus.alu_op     = alu_op_q;
  assign bus.alu_op1    = alu_op1_q;
  assign bus.alu_op2    = alu_op2_q;
  assign bus.rsp_valid  = rsp_vld;
  assign bus.rsp_result = rsp_result_q;
  assign bus.rsp_cmp    = rsp_cmp_q;
  assign bus.rsp_id     = rsp_id_q;
  assign bus.busy       = (state == BUSY);
endmodule

// File: tb/tb_falu_scheduler.sv
// Directed bench for falu_scheduler: stimulus pushes expected responses, a negedge monitor pops and compares.
module tb_falu_scheduler;
  localparam int NR  = 4;
  localparam int DC  = 4;
  localparam int IDW = 2;
  localparam logic [3:0] OP_ADD = 4'h0, OP_MUL = 4'h2, OP_DIV = 4'h3, OP_SLT = 4'h4, OP_EQ = 4'h5;

  typedef struct {
    int          id;
    logic [31:0] res;
    logic        cmp;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  exp_t q[$];
  exp_t mon_e;
  logic lt;

  falu_scheduler_if #(.NUM_REQ(NR), .ID_W(IDW)) bus ();

  falu_scheduler #(.NUM_REQ(NR), .DIV_CYCLES(DC), .FALU_DIV(OP_DIV)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Stand-in ALU: knows only the vectors used here; anything else returns op1^op2.
  always_comb begin
    bus.alu_result = bus.alu_op1 ^ bus.alu_op2;
    bus.alu_cmp    = 1'b0;
    lt             = 1'b0;
    case (bus.alu_op)
      OP_ADD: if (bus.alu_op1 == 32'h3F800000 && bus.alu_op2 == 32'h40000000) bus.alu_result = 32'h40400000;
      OP_MUL: if (bus.alu_op1 == 32'h40000000 && bus.alu_op2 == 32'h40400000) bus.alu_result = 32'h40C00000;
      OP_DIV: if (bus.alu_op1 == 32'h40C00000 && bus.alu_op2 == 32'h40000000) bus.alu_result = 32'h40400000;
      OP_SLT: begin
        if (bus.alu_op1[31] != bus.alu_op2[31])
          lt = bus.alu_op1[31] && ((bus.alu_op1[30:0] | bus.alu_op2[30:0]) != 31'd0);
        else if (bus.alu_op1[31])
          lt = bus.alu_op1[30:0] > bus.alu_op2[30:0];
        else
          lt = bus.alu_op1[30:0] < bus.alu_op2[30:0];
        bus.alu_cmp    = lt;
        bus.alu_result = {31'd0, lt};
      end
      OP_EQ: begin
        bus.alu_cmp    = (bus.alu_op1 == bus.alu_op2);
        bus.alu_result = {31'd0, bus.alu_op1 == bus.alu_op2};
      end
      default: ;
    endcase
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (bus.rsp_valid !== '0) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_rsp: rsp_valid=%b with nothing pending at cycle %0d", bus.rsp_valid, cyc);
      end else begin
        mon_e = q.pop_front();
        chk("rsp_valid", 32'(bus.rsp_valid), 32'(1 << mon_e.id));
        chk("rsp_id", 32'(bus.rsp_id), 32'(mon_e.id));
        chk("rsp_result", bus.rsp_result, mon_e.res);
        chk("rsp_cmp", 32'(bus.rsp_cmp), 32'(mon_e.cmp));
        chk("rsp_cycle", 32'(cyc), 32'(mon_e.cyc));
      end
    end
  end

  // Called at the negedge where the grant is seen; accept edge follows, capture 'hold' edges later.
  task automatic push_exp(input int id, input logic [31:0] res, input logic cmp, input int hold);
    exp_t e;
    e.id  = id;
    e.res = res;
    e.cmp = cmp;
    e.cyc = cyc + 1 + hold;
    q.push_back(e);
  endtask

  task automatic drive(input int id, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.req_op[id]    = op;
    bus.req_op1[id]   = a;
    bus.req_op2[id]   = b;
    bus.req_valid[id] = 1'b1;
  endtask

  task automatic wait_grant(input int id, input int limit, output int waits);
    waits = 0;
    @(negedge clk);
    while (!bus.req_ready[id] && waits < limit) begin
      waits++;
      @(negedge clk);
    end
    if (!bus.req_ready[id]) begin
      total++;
      bad++;
      $display("FAIL grant_timeout_req%0d: no grant after %0d cycles", id, limit);
      waits = -1;
    end
  endtask

  task automatic drop_after_edge(input int id);
    @(posedge clk);
    #1;
    bus.req_valid[id] = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_req_ready"}, 32'(bus.req_ready), 32'h0);
    chk({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 32'h0);
    chk({tag, "_rsp_result"}, bus.rsp_result, 32'h0);
    chk({tag, "_rsp_cmp"}, 32'(bus.rsp_cmp), 32'h0);
    chk({tag, "_rsp_id"}, 32'(bus.rsp_id), 32'h0);
    chk({tag, "_busy"}, 32'(bus.busy), 32'h0);
    chk({tag, "_alu_op"}, 32'(bus.alu_op), 32'h0);
    chk({tag, "_alu_op1"}, bus.alu_op1, 32'h0);
    chk({tag, "_alu_op2"}, bus.alu_op2, 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    int order [5] = '{0, 1, 2, 3, 0};
    bus.req_valid = '0;
    bus.req_op    = '0;
    bus.req_op1   = '0;
    bus.req_op2   = '0;
    repeat (2) @(posedge clk);
    #1;
    reset_checks("reset");
    reset = 1'b0;

    // Round robin: everyone holds MUL; rr_ptr starts at 0.
    for (int i = 0; i < NR; i++) drive(i, OP_MUL, 32'h40000000, 32'h40400000);
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      chk("rr_grant", 32'(bus.req_ready), 32'(1 << order[n]));
      push_exp(order[n], 32'h40C00000, 1'b0, 1);
      @(posedge clk);
    end
    #1;
    bus.req_valid = '0;
    idle(4);

    // Single ADD from requester 0 while idle.
    drive(0, OP_ADD, 32'h3F800000, 32'h40000000);
    wait_grant(0, 10, w);
    chk("add_grant_wait", 32'(w), 32'd0);
    push_exp(0, 32'h40400000, 1'b0, 1);
    drop_after_edge(0);
    chk("add_busy", 32'(bus.busy), 32'd1);
    idle(4);
    chk("idle_busy", 32'(bus.busy), 32'd0);

    // DIV from requester 2 with requester 0 waiting behind it.
    drive(2, OP_DIV, 32'h40C00000, 32'h40000000);
    wait_grant(2, 10, w);
    chk("div_grant_wait", 32'(w), 32'd0);
    push_exp(2, 32'h40400000, 1'b0, DC);
    drop_after_edge(2);
    drive(0, OP_ADD, 32'h3F800000, 32'h40000000);
    for (int k = 1; k < DC; k++) begin
      @(negedge clk);
      chk("div_ready_low", 32'(bus.req_ready), 32'h0);
      chk("div_alu_op", 32'(bus.alu_op), 32'(OP_DIV));
      chk("div_op1_hold", bus.alu_op1, 32'h40C00000);
      chk("div_op2_hold", bus.alu_op2, 32'h40000000);
    end
    @(negedge clk);
    chk("div_capture_grant", 32'(bus.req_ready), 32'h1);
    push_exp(0, 32'h40400000, 1'b0, 1);
    drop_after_edge(0);
    idle(4);

    // Back-to-back from requester 1: DIV then ADD, valid held throughout.
    drive(1, OP_DIV, 32'h40C00000, 32'h40000000);
    wait_grant(1, 10, w);
    chk("b2b_div_wait", 32'(w), 32'd0);
    push_exp(1, 32'h40400000, 1'b0, DC);
    @(posedge clk);
    #1;
    drive(1, OP_ADD, 32'h3F800000, 32'h40000000);
    wait_grant(1, 10, w);
    chk("b2b_add_wait", 32'(w), 32'(DC - 1));
    push_exp(1, 32'h40400000, 1'b0, 1);
    drop_after_edge(1);
    idle(4);

    // Compares.
    drive(3, OP_SLT, 32'hBF800000, 32'h3F800000);
    wait_grant(3, 10, w);
    push_exp(3, 32'h1, 1'b1, 1);
    drop_after_edge(3);
    drive(2, OP_SLT, 32'h3F800000, 32'hBF800000);
    wait_grant(2, 10, w);
    push_exp(2, 32'h0, 1'b0, 1);
    drop_after_edge(2);
    drive(0, OP_EQ, 32'h12345678, 32'h12345678);
    wait_grant(0, 10, w);
    push_exp(0, 32'h1, 1'b1, 1);
    drop_after_edge(0);
    idle(4);

    // Reset in DIV hold cycle 2: op is aborted, no response may appear.
    drive(2, OP_DIV, 32'h40C00000, 32'h40000000);
    wait_grant(2, 10, w);
    drop_after_edge(2);
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    reset_checks("midop_reset");
    idle(2);
    reset = 1'b0;
    idle(8);
    for (int i = 0; i < NR; i++) drive(i, OP_ADD, 32'h3F800000, 32'h40000000);
    @(negedge clk);
    chk("post_reset_grant", 32'(bus.req_ready), 32'h1);
    push_exp(0, 32'h40400000, 1'b0, 1);
    @(posedge clk);
    #1;
    bus.req_valid = '0;
    idle(5);

    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
